// File: rtl/seq_detect_pkg.sv
// -----------------------------------------------------------------------------
// seq_detect_pkg
// Shared definitions for the parametrised serial pattern detector:
//   state_t   - detector state (FILL: collecting len bits, HUNT: matching)
//   MIN_LEN   - shortest pattern length accepted at configuration time
//   clamp_len - maps a requested pattern length into MIN_LEN..max_len
// -----------------------------------------------------------------------------
package seq_detect_pkg;

    typedef enum logic {
        S_FILL = 1'b0,
        S_HUNT = 1'b1
    } state_t;

    localparam int unsigned MIN_LEN = 32'd2;

    // Clamp a requested length to the nearest legal limit.
    function automatic int unsigned clamp_len(input int unsigned req,
                                              input int unsigned max_len);
        int unsigned res_s;
        if (req < MIN_LEN) begin
            res_s = MIN_LEN;
        end else if (req > max_len) begin
            res_s = max_len;
        end else begin
            res_s = req;
        end
        return res_s;
    endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear (clear has priority).
// Ports:
//   clk   - clock
//   rst   - asynchronous reset, active-high
//   inc   - count one event
//   clr   - synchronous clear, wins over inc
//   value - registered count, sticks at all ones
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] value
);

    logic [CNT_W-1:0] value_r;

    // Count register: clear first, then saturating increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_r <= '0;
        end else if (clr) begin
            value_r <= '0;
        end else if (inc && (value_r != {CNT_W{1'b1}})) begin
            value_r <= value_r + CNT_W'(1'b1);
        end else begin
            value_r <= value_r;
        end
    end

    assign value = value_r;

endmodule

// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
// Serial bit-pattern detector with runtime-loadable pattern, don't-care mask
// and length, overlapping / non-overlapping matching and a saturating match
// counter.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   in_valid, in      - serial bit and its qualifier
//   cfg_load          - strobe latching cfg_pat/cfg_mask/cfg_len/cfg_ovl
//   cfg_pat, cfg_mask - pattern (right aligned) and compare mask (1 = compare)
//   cfg_len           - active length, clamped into 2..PAT_W
//   cfg_ovl           - 1 = overlapping matches allowed
//   clr_cnt           - synchronous clear of match_cnt
//   out               - registered one-cycle match pulse
//   match_cnt         - saturating number of matches
//   busy              - high while hunting (window fully populated)
// -----------------------------------------------------------------------------
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int             PAT_W   = 5,
    parameter int             CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(5'b11011),
    parameter int             RST_LEN = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         in,
    input  logic                         cfg_load,
    input  logic [PAT_W-1:0]             cfg_pat,
    input  logic [PAT_W-1:0]             cfg_mask,
    input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
    input  logic                         cfg_ovl,
    input  logic                         clr_cnt,
    output logic                         out,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         busy
);

    localparam int LEN_W = $clog2(PAT_W + 1);

    state_t           state_r;
    logic [PAT_W-1:0] hist_r;
    logic [PAT_W-1:0] pat_r;
    logic [PAT_W-1:0] mask_r;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] fill_r;
    logic             ovl_r;
    logic             out_r;
    logic             busy_r;

    logic [PAT_W-1:0] hist_next_s;
    logic [PAT_W-1:0] len_mask_s;
    logic [LEN_W-1:0] fill_next_s;
    logic [LEN_W-1:0] cfg_len_clamped_s;
    logic             window_hit_s;
    logic             eval_s;
    logic             hit_s;

    // Window compare on the history including the bit being consumed now.
    always_comb begin
        hist_next_s = {hist_r[PAT_W-2:0], in};
        fill_next_s = fill_r + LEN_W'(1'b1);
        len_mask_s  = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask_s[i] = (i < int'(len_r));
        end
        window_hit_s = (((hist_next_s ^ pat_r) & mask_r & len_mask_s) == '0);
        // A hit counts in HUNT, or on the bit that completes the fill.
        eval_s = (state_r == S_HUNT) || (fill_next_s == len_r);
        hit_s  = in_valid && !cfg_load && eval_s && window_hit_s;
        cfg_len_clamped_s = LEN_W'(clamp_len(32'(cfg_len), 32'(PAT_W)));
    end

    // Configuration, history and FILL/HUNT state machine with registered flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_FILL;
            hist_r  <= '0;
            fill_r  <= '0;
            pat_r   <= RST_PAT;
            mask_r  <= '1;
            len_r   <= LEN_W'(RST_LEN);
            ovl_r   <= 1'b1;
            out_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else if (cfg_load) begin
            // New configuration restarts the search; the bit presented now is dropped.
            pat_r   <= cfg_pat;
            mask_r  <= cfg_mask;
            len_r   <= cfg_len_clamped_s;
            ovl_r   <= cfg_ovl;
            hist_r  <= '0;
            fill_r  <= '0;
            state_r <= S_FILL;
            out_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else if (in_valid) begin
            hist_r <= hist_next_s;
            out_r  <= hit_s;
            if (hit_s && !ovl_r) begin
                // Non-overlapping: matched bits are consumed, refill from scratch.
                state_r <= S_FILL;
                fill_r  <= '0;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    S_FILL: begin
                        fill_r <= fill_next_s;
                        if (fill_next_s == len_r) begin
                            state_r <= S_HUNT;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= S_FILL;
                            busy_r  <= 1'b0;
                        end
                    end
                    S_HUNT: begin
                        state_r <= S_HUNT;
                        busy_r  <= 1'b1;
                    end
                    default: begin
                        state_r <= S_FILL;
                        fill_r  <= '0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end else begin
            out_r <= 1'b0;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_s),
        .clr   (clr_cnt),
        .value (match_cnt)
    );

    assign out  = out_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_seq_detect_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_param
// Two detector instances share one stimulus stream: u_dut0 with the default
// parameters (PAT_W=5, CNT_W=8) and u_dut1 with PAT_W=8, CNT_W=2 for the
// length-clamp and counter-saturation cases. Each is followed by a behavioural
// model that counts bits since the last restart and compares the most recent
// len bits against the pattern.
// -----------------------------------------------------------------------------
module tb_seq_detect_param;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       din;
    logic       cfg_load;
    logic [7:0] cfg_pat;
    logic [7:0] cfg_mask;
    int         cfg_len_req;
    logic [2:0] cfg_len0;
    logic [3:0] cfg_len1;
    logic       cfg_ovl;
    logic       clr_cnt;

    logic       dout0;
    logic [7:0] cnt0;
    logic       busy0;
    logic       dout1;
    logic [1:0] cnt1;
    logic       busy1;

    int vectors;
    int miscompares;

    // behavioural model state, index 0 -> u_dut0, 1 -> u_dut1
    logic [31:0] m_hist [2];
    logic [31:0] m_pat  [2];
    logic [31:0] m_mask [2];
    int          m_len  [2];
    int          m_since[2];
    int          m_cnt  [2];
    bit          m_ovl  [2];
    bit          m_out  [2];

    assign cfg_len0 = cfg_len_req[2:0];
    assign cfg_len1 = cfg_len_req[3:0];

    seq_detect_param u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (din),
        .cfg_load  (cfg_load),
        .cfg_pat   (cfg_pat[4:0]),
        .cfg_mask  (cfg_mask[4:0]),
        .cfg_len   (cfg_len0),
        .cfg_ovl   (cfg_ovl),
        .clr_cnt   (clr_cnt),
        .out       (dout0),
        .match_cnt (cnt0),
        .busy      (busy0)
    );

    seq_detect_param #(
        .PAT_W   (8),
        .CNT_W   (2),
        .RST_PAT (8'h1B),
        .RST_LEN (5)
    ) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (din),
        .cfg_load  (cfg_load),
        .cfg_pat   (cfg_pat),
        .cfg_mask  (cfg_mask),
        .cfg_len   (cfg_len1),
        .cfg_ovl   (cfg_ovl),
        .clr_cnt   (clr_cnt),
        .out       (dout1),
        .match_cnt (cnt1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pat_w(input int k);
        return (k == 0) ? 5 : 8;
    endfunction

    function automatic int cnt_max(input int k);
        return (k == 0) ? 255 : 3;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_hist[k]  = 32'd0;
            m_pat[k]   = (k == 0) ? 32'h1B : 32'h1B;
            m_mask[k]  = (32'd1 << pat_w(k)) - 32'd1;
            m_len[k]   = 5;
            m_since[k] = 0;
            m_cnt[k]   = 0;
            m_ovl[k]   = 1'b1;
            m_out[k]   = 1'b0;
        end
    endtask

    // One clock of the reference behaviour for instance k.
    task automatic model_step(input int k);
        bit          hit;
        int          lv;
        logic [31:0] wmask;
        hit   = 1'b0;
        wmask = (32'd1 << pat_w(k)) - 32'd1;
        if (cfg_load) begin
            m_pat[k]  = 32'(cfg_pat) & wmask;
            m_mask[k] = 32'(cfg_mask) & wmask;
            lv = cfg_len_req & ((k == 0) ? 7 : 15);
            if (lv < 2) lv = 2;
            if (lv > pat_w(k)) lv = pat_w(k);
            m_len[k]   = lv;
            m_ovl[k]   = cfg_ovl;
            m_hist[k]  = 32'd0;
            m_since[k] = 0;
        end else if (in_valid) begin
            m_hist[k] = {m_hist[k][30:0], din};
            m_since[k]++;
            if (m_since[k] >= m_len[k]) begin
                hit = 1'b1;
                for (int i = 0; i < m_len[k]; i++) begin
                    if (m_mask[k][i] && (m_hist[k][i] != m_pat[k][i])) hit = 1'b0;
                end
            end
            if (hit && !m_ovl[k]) m_since[k] = 0;
        end
        m_out[k] = hit;
        if (clr_cnt) m_cnt[k] = 0;
        else if (hit && (m_cnt[k] < cnt_max(k))) m_cnt[k]++;
    endtask

    task automatic compare_all();
        check("out0",  32'(dout0), 32'(m_out[0]));
        check("cnt0",  32'(cnt0),  32'(m_cnt[0]));
        check("busy0", 32'(busy0), 32'(m_since[0] >= m_len[0]));
        check("out1",  32'(dout1), 32'(m_out[1]));
        check("cnt1",  32'(cnt1),  32'(m_cnt[1]));
        check("busy1", 32'(busy1), 32'(m_since[1] >= m_len[1]));
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Asynchronous reset: outputs must drop without a clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic b);
        in_valid = 1'b1;
        din      = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send(bits[i]);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input logic [7:0] p, input logic [7:0] m, input int len, input logic ovl);
        cfg_pat     = p;
        cfg_mask    = m;
        cfg_len_req = len;
        cfg_ovl     = ovl;
        cfg_load    = 1'b1;
        in_valid    = 1'b1;
        din         = 1'b1;
        tick();
        cfg_load = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        din         = 1'b0;
        cfg_load    = 1'b0;
        cfg_pat     = 8'h00;
        cfg_mask    = 8'h00;
        cfg_len_req = 0;
        cfg_ovl     = 1'b0;
        clr_cnt     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // reset defaults: 11011 pulses after bit 5
        send_bits(32'b1101, 4);
        check("t1_no_early", 32'(dout0), 32'd0);
        send(1'b1);
        check("t1_pulse", 32'(dout0), 32'd1);
        check("t1_cnt", 32'(cnt0), 32'd1);
        idle(1);
        check("t1_one_cycle", 32'(dout0), 32'd0);

        // overlapping, then non-overlapping on the same stream
        do_reset();
        send_bits(32'b11011011, 8);
        check("t2_ovl_cnt", 32'(cnt0), 32'd2);
        load(8'h1B, 8'hFF, 5, 1'b0);
        send_bits(32'b11011011, 8);
        check("t2_novl_cnt", 32'(cnt0), 32'd3);
        idle(2);

        // masked 4-bit pattern
        load(8'h0A, 8'h0B, 4, 1'b1);
        send_bits(32'b1010, 4);
        check("t3_1010", 32'(dout0), 32'd1);
        send_bits(32'b1110, 4);
        check("t3_1110", 32'(dout0), 32'd1);
        load(8'h0A, 8'h0B, 4, 1'b1);
        send_bits(32'b0010, 4);
        check("t3_0010", 32'(dout0), 32'd0);

        // valid gaps do not break the match
        do_reset();
        send_bits(32'b11, 2);
        idle(3);
        send_bits(32'b011, 3);
        check("t4_gap_pulse", 32'(dout0), 32'd1);

        // saturation on the 2-bit counter, then clr coincident with a hit
        do_reset();
        send_bits(32'b11011011011011011, 17);
        check("t5_sat", 32'(cnt1), 32'd3);
        send_bits(32'b01, 2);
        clr_cnt = 1'b1;
        send(1'b1);
        clr_cnt = 1'b0;
        check("t5_clr_out", 32'(dout1), 32'd1);
        check("t5_clr_cnt", 32'(cnt1), 32'd0);

        // reset mid-pattern loses the partial match
        do_reset();
        send_bits(32'b110, 3);
        do_reset();
        send_bits(32'b11, 2);
        check("t6_no_pulse", 32'(dout0), 32'd0);
        send_bits(32'b11011, 5);
        check("t6_pulse", 32'(dout0), 32'd1);

        // length 9 clamps to 8 on the 8-bit instance
        load(8'hFF, 8'hFF, 9, 1'b1);
        send_bits(32'h7F, 7);
        check("t7_before", 32'(dout1), 32'd0);
        send(1'b1);
        check("t7_clamp8", 32'(dout1), 32'd1);

        // all-zero mask: every bit after the fill hits
        load(8'h00, 8'h00, 3, 1'b1);
        send_bits(32'b010, 3);
        check("t8_mask0", 32'(dout0), 32'd1);
        send(1'b0);
        check("t8_mask0_next", 32'(dout0), 32'd1);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cfg_load = ($urandom_range(0, 63) == 0);
                if (cfg_load) begin
                    cfg_pat     = 8'($urandom);
                    cfg_mask    = 8'($urandom) & 8'($urandom);
                    cfg_len_req = $urandom_range(0, 15);
                    cfg_ovl     = 1'($urandom);
                end
                clr_cnt  = ($urandom_range(0, 49) == 0);
                in_valid = ($urandom_range(0, 3) != 0);
                din      = 1'($urandom);
                tick();
            end
        end
        cfg_load = 1'b0;
        clr_cnt  = 1'b0;
        in_valid = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
